// File: rtl/alu_issue_pkg.sv
// Shared types and decode helpers for the ALU issue sequencer.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [2:0] SLL    = 3'b001;
  localparam logic [2:0] SR     = 3'b101;

  // Shifts are the only ops for which the ALU needs more than one cycle.
  function automatic logic is_shift(input logic [11:0] decinst);
    return ((decinst[6:0] == OP) || (decinst[6:0] == OP_IMM)) &&
           ((decinst[9:7] == SLL) || (decinst[9:7] == SR));
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded op at a time to the mriscvcore ALU and buffers its result.
// Optional SHIFT watchdog enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_decinst,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_inm,
  input  logic [4:0]  req_rd,
  output logic        alu_en,
  output logic [11:0] alu_decinst,
  output logic [31:0] alu_operando1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_inm,
  input  logic [31:0] alu_salida,
  input  logic        alu_comparativa,
  input  logic        alu_carry,
  input  logic        alu_sl_ok,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_cmp,
  output logic        res_carry,
  output logic [4:0]  res_rd,
  output logic        res_err
);

  state_e      state_q;
  logic [11:0] decinst_q;
  logic [31:0] rs1_q, rs2_q, inm_q;
  logic [4:0]  rd_q;
  logic        alu_en_q, res_valid_q;
  logic [31:0] res_data_q;
  logic        res_cmp_q, res_carry_q;
  logic [4:0]  res_rd_q;

`ifdef ALU_ISSUE_TIMEOUT_EN
  logic [7:0]  wd_q;
  logic        res_err_q;
  localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);
`else
  logic [7:0]  unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  // Operand registers feed the ALU directly so they stay put during EXEC/SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      decinst_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      inm_q       <= '0;
      rd_q        <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cmp_q   <= 1'b0;
      res_carry_q <= 1'b0;
      res_rd_q    <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wd_q        <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            decinst_q <= req_decinst;
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            inm_q     <= req_inm;
            rd_q      <= req_rd;
            alu_en_q  <= 1'b1;
            state_q   <= is_shift(req_decinst) ? SHIFT : EXEC;
`ifdef ALU_ISSUE_TIMEOUT_EN
            wd_q      <= '0;
`endif
          end
        end
        EXEC: begin
          res_data_q  <= alu_salida;
          res_cmp_q   <= alu_comparativa;
          res_carry_q <= alu_carry;
          res_rd_q    <= rd_q;
          alu_en_q    <= 1'b0;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
`ifdef ALU_ISSUE_TIMEOUT_EN
          res_err_q   <= 1'b0;
`endif
        end
        SHIFT: begin
          if (alu_sl_ok) begin
            res_data_q  <= alu_salida;
            res_cmp_q   <= alu_comparativa;
            res_carry_q <= alu_carry;
            res_rd_q    <= rd_q;
            alu_en_q    <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= RESP;
`ifdef ALU_ISSUE_TIMEOUT_EN
            res_err_q   <= 1'b0;
          end else if (wd_q == WdLast) begin
            res_data_q  <= '0;
            res_cmp_q   <= 1'b0;
            res_carry_q <= 1'b0;
            res_rd_q    <= rd_q;
            res_err_q   <= 1'b1;
            alu_en_q    <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wd_q <= wd_q + 8'd1;
`endif
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE) && !reset;
  assign alu_en        = alu_en_q;
  assign alu_decinst   = decinst_q;
  assign alu_operando1 = rs1_q;
  assign alu_rs2       = rs2_q;
  assign alu_inm       = inm_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_cmp       = res_cmp_q;
  assign res_carry     = res_carry_q;
  assign res_rd        = res_rd_q;

`ifdef ALU_ISSUE_TIMEOUT_EN
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed-vector bench for alu_issue_ctrl with a small behavioural ALU on the far side.
// Adds a watchdog scenario when ALU_ISSUE_TIMEOUT_EN is defined.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [11:0] decinst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] inm;
    logic [4:0]  rd;
    logic [31:0] expData;
    logic        expCmp;
    logic        expCarry;
    logic        expErr;
    int          expEn;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [11:0] req_decinst;
  logic [31:0] req_rs1, req_rs2, req_inm;
  logic [4:0]  req_rd;
  logic        alu_en;
  logic [11:0] alu_decinst;
  logic [31:0] alu_operando1, alu_rs2, alu_inm;
  logic [31:0] alu_salida;
  logic        alu_comparativa, alu_carry, alu_sl_ok;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_cmp, res_carry, res_err;
  logic [4:0]  res_rd;

  int vecCount  = 0;
  int missCount = 0;

  logic        slokDisable = 1'b0;
  logic        slokForce   = 1'b0;
  logic [31:0] shiftCnt    = '0;
  logic [31:0] modelB, modelRes;
  logic [32:0] sum33;
  logic        modelCmp, modelCarry, isShiftOp, slOk;

  alu_issue_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_decinst(req_decinst),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_inm(req_inm), .req_rd(req_rd),
    .alu_en(alu_en), .alu_decinst(alu_decinst), .alu_operando1(alu_operando1),
    .alu_rs2(alu_rs2), .alu_inm(alu_inm),
    .alu_salida(alu_salida), .alu_comparativa(alu_comparativa),
    .alu_carry(alu_carry), .alu_sl_ok(alu_sl_ok),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cmp(res_cmp), .res_carry(res_carry), .res_rd(res_rd), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: results only valid while en is high, shifts only on sl_ok.
  always_comb begin
    modelB     = (alu_decinst[6:0] == 7'b0010011) ? alu_inm : alu_rs2;
    modelRes   = 32'h0;
    modelCmp   = 1'b0;
    modelCarry = 1'b0;
    isShiftOp  = 1'b0;
    sum33      = 33'h0;
    case (alu_decinst[9:7])
      3'b000: begin
        if (alu_decinst[6:0] == 7'b0110011 && alu_decinst[11])
          sum33 = {1'b0, alu_operando1} - {1'b0, modelB};
        else
          sum33 = {1'b0, alu_operando1} + {1'b0, modelB};
        modelRes   = sum33[31:0];
        modelCarry = sum33[32];
      end
      3'b010: begin
        modelCmp = $signed(alu_operando1) < $signed(modelB);
        modelRes = {31'b0, modelCmp};
      end
      3'b011: begin
        modelCmp = alu_operando1 < modelB;
        modelRes = {31'b0, modelCmp};
      end
      3'b100: modelRes = alu_operando1 ^ modelB;
      3'b110: modelRes = alu_operando1 | modelB;
      3'b111: modelRes = alu_operando1 & modelB;
      3'b001: begin
        isShiftOp = 1'b1;
        modelRes  = alu_operando1 << modelB[4:0];
      end
      3'b101: begin
        isShiftOp = 1'b1;
        if (alu_decinst[10])
          modelRes = $signed(alu_operando1) >>> modelB[4:0];
        else
          modelRes = alu_operando1 >> modelB[4:0];
      end
      default: modelRes = 32'h0;
    endcase
  end

  // The model finishes a shift after shamt cycles of en.
  always @(posedge clk) shiftCnt <= alu_en ? shiftCnt + 32'd1 : 32'd0;

  assign slOk            = alu_en && isShiftOp && !slokDisable && (shiftCnt == {27'b0, modelB[4:0]});
  assign alu_sl_ok       = slOk | slokForce;
  assign alu_salida      = !alu_en ? 32'hdeadbeef : (isShiftOp && !slOk) ? 32'h5a5a5a5a : modelRes;
  assign alu_comparativa = alu_en & modelCmp;
  assign alu_carry       = alu_en & modelCarry;

  // One comparison: bumps the count and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveReq(input vec_t v);
    req_decinst = v.decinst;
    req_rs1     = v.rs1;
    req_rs2     = v.rs2;
    req_inm     = v.inm;
    req_rd      = v.rd;
    req_valid   = 1'b1;
  endtask

  // Issues one op, waits for its result, checks it and completes the handshake.
  task automatic applyStimulus(input vec_t v, input int idx);
    int enCount;
    int lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    checkOutput({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    driveReq(v);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput({tag, ".decinst"}, {20'b0, alu_decinst}, {20'b0, v.decinst});
    checkOutput({tag, ".op1"}, alu_operando1, v.rs1);
    checkOutput({tag, ".busy"}, {31'b0, req_ready}, 32'd0);
    enCount = 0;
    lat     = 1;
    while (!res_valid && lat < 100) begin
      if (alu_en) enCount++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".res_valid"}, {31'b0, res_valid}, 32'd1);
    checkOutput({tag, ".en_cycles"}, enCount, v.expEn);
    checkOutput({tag, ".latency"}, lat, v.expEn + 1);
    checkOutput({tag, ".data"}, res_data, v.expData);
    checkOutput({tag, ".cmp"}, {31'b0, res_cmp}, {31'b0, v.expCmp});
    checkOutput({tag, ".carry"}, {31'b0, res_carry}, {31'b0, v.expCarry});
    checkOutput({tag, ".err"}, {31'b0, res_err}, {31'b0, v.expErr});
    checkOutput({tag, ".rd"}, {27'b0, res_rd}, {27'b0, v.rd});
    checkOutput({tag, ".en_off"}, {31'b0, alu_en}, 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, ".valid_drop"}, {31'b0, res_valid}, 32'd0);
    checkOutput({tag, ".ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  vec_t vecs[9];
  vec_t tv;

  initial begin
    int seen;
    vecs[0] = '{12'b000000110011, 32'hc0404040, 32'h00000fff, 32'h0, 5'd1, 32'hc040503f, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{12'b100000110011, 32'hc0404040, 32'h00000fff, 32'h0, 5'd2, 32'hc0403041, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{12'b000100010011, 32'hc0404040, 32'h0, 32'h00000fff, 5'd3, 32'h00000001, 1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{12'b000000110011, 32'hffffffff, 32'h00000001, 32'h0, 5'd4, 32'h00000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{12'b001000010011, 32'hf0f0f0f0, 32'h0, 32'h0ff00ff0, 5'd5, 32'hff00ff00, 1'b0, 1'b0, 1'b0, 1};
    vecs[5] = '{12'b011010010011, 32'hc0404040, 32'h0, 32'h00000fff, 5'd6, 32'hffffffff, 1'b0, 1'b0, 1'b0, 32};
    vecs[6] = '{12'b000010110011, 32'h00000003, 32'h00000004, 32'h0, 5'd7, 32'h00000030, 1'b0, 1'b0, 1'b0, 5};
    vecs[7] = '{12'b000110110011, 32'h00000001, 32'hffffffff, 32'h0, 5'd8, 32'h00000001, 1'b1, 1'b0, 1'b0, 1};
    vecs[8] = '{12'b001010010011, 32'h80000000, 32'h0, 32'h00000004, 5'd9, 32'h08000000, 1'b0, 1'b0, 1'b0, 5};

    reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_decinst = '0; req_rs1 = '0; req_rs2 = '0; req_inm = '0; req_rd = '0;
    @(negedge clk);
    checkOutput("rst.ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rst.en", {31'b0, alu_en}, 32'd0);
    checkOutput("rst.valid", {31'b0, res_valid}, 32'd0);
    checkOutput("rst.data", res_data, 32'd0);
    checkOutput("rst.decinst", {20'b0, alu_decinst}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle.ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Backpressure: result must hold and a waiting request must stay out.
    driveReq(vecs[0]);
    @(negedge clk);
    driveReq(vecs[1]);
    for (int i = 0; i < 10 && !res_valid; i++) @(negedge clk);
    slokForce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp.valid", {31'b0, res_valid}, 32'd1);
      checkOutput("bp.data", res_data, 32'hc040503f);
      checkOutput("bp.ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    slokForce = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("bp.handoff", {31'b0, res_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("bp.second_en", {31'b0, alu_en}, 32'd1);
    checkOutput("bp.second_op", {20'b0, alu_decinst}, {20'b0, vecs[1].decinst});
    for (int i = 0; i < 10 && !res_valid; i++) @(negedge clk);
    checkOutput("bp.second_data", res_data, 32'hc0403041);
    checkOutput("bp.second_rd", {27'b0, res_rd}, 32'd2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Reset in the middle of a shift drops the operation.
    driveReq(vecs[5]);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid.en", {31'b0, alu_en}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid.rst_en", {31'b0, alu_en}, 32'd0);
    checkOutput("mid.rst_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("mid.rst_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("mid.rst_op1", alu_operando1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid || alu_en) seen++;
    end
    checkOutput("mid.no_result", seen, 32'd0);
    checkOutput("mid.ready", {31'b0, req_ready}, 32'd1);

`ifdef ALU_ISSUE_TIMEOUT_EN
    slokDisable = 1'b1;
    tv = vecs[5];
    tv.expData = 32'h0;
    tv.expErr  = 1'b1;
    tv.expEn   = 40;
    applyStimulus(tv, 90);
    slokDisable = 1'b0;
    applyStimulus(vecs[0], 91);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] bench time limit");
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue sequencer that drives the mriscvcore ALU from the requester side of its `en`/`decinst`/`sl_ok` interface. It accepts one decoded ALU operation at a time over a valid/ready request port and presents operands and the 12-bit `decinst` to the ALU. It holds `en` for as long as the operation needs: one cycle for single-cycle ops, until `sl_ok` for shifts. It then captures `SALIDA_Alu`/`SALIDA_comparativa`/`carry` into a result register offered over a valid/ready result port. It sits between the decode stage and writeback.

## Interface
- `TIMEOUT_CYCLES`, 40: maximum cycles to wait for `sl_ok` (used only with the watchdog).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_decinst` in 12: decoded op. [6:0] opcode, [9:7] funct3, [10] arithmetic-shift select, [11] subtract select.
- `req_rs1`, `req_rs2`, `req_inm` in 32 each: operand 1, register operand 2, immediate.
- `req_rd` in 5: destination tag, carried through.
- `alu_en` out 1, `alu_decinst` out 12, `alu_operando1`/`alu_rs2`/`alu_inm` out 32: ALU drive.
- `alu_salida` in 32, `alu_comparativa` in 1, `alu_carry` in 1, `alu_sl_ok` in 1: ALU returns.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 32, `res_cmp` out 1, `res_carry` out 1, `res_rd` out 5, `res_err` out 1: captured result.

## Operation
- States: IDLE, EXEC, SHIFT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields into operand registers and go to EXEC, or to SHIFT if the op is a shift.
- A shift is opcode 0010011 or 0110011 with funct3 001 or 101.
- EXEC: `alu_en`=1 for exactly one cycle. At the end of the cycle, capture ALU outputs, set `res_err`=0, go to RESP.
- SHIFT: `alu_en` held at 1. At the edge where `alu_sl_ok`=1 is sampled, capture outputs and go to RESP.
- RESP: `res_valid`=1 and `alu_en`=0. On `res_ready`, go to IDLE.
- Result registers and `res_valid` are stable while `res_valid`=1 and `res_ready`=0.
- `alu_decinst` and the operand outputs come straight from the operand registers; they are stable throughout EXEC/SHIFT.
- No request is accepted outside IDLE; `req_ready`=0 in EXEC/SHIFT/RESP.
- `alu_sl_ok` asserted outside SHIFT is ignored.
- Reset at any point, including mid-shift: state=IDLE, all outputs 0, operand/result registers 0. An in-flight operation is dropped with no result.

## Timing
- Reset values: `req_ready`=0 while `reset`=1, then 1 in IDLE. `alu_en`=0, `res_valid`=0, all data outputs 0.
- Non-shift latency: accept edge → `alu_en` high 1 cycle → `res_valid` on the next cycle, i.e. 2 cycles from accept to `res_valid`.
- Shift latency: 1 + (cycles until `sl_ok`) + 0 cycles; `res_valid` rises the cycle after `sl_ok` is sampled.
- Back-to-back throughput: one op per 3 cycles minimum, because the RESP→IDLE handoff costs one cycle even with `res_ready` tied high.

## Configuration
- `ALU_ISSUE_TIMEOUT_EN` defined: an 8-bit watchdog counts cycles spent in SHIFT.
  - If the count reaches `TIMEOUT_CYCLES` without `sl_ok`, capture `res_data`=0 and `res_err`=1, then go to RESP.
  - The counter clears on entering SHIFT.
- Not defined: SHIFT waits indefinitely, and `res_err` is tied 0.

## Structure
- Shared package `alu_issue_pkg`:
  - state enum;
  - opcode constants OP=7'b0110011 and OP_IMM=7'b0010011;
  - funct3 constants SLL=3'b001 and SR=3'b101;
  - `is_shift` function.
- No sub-module is needed; the optional watchdog counter is inline.

## Test plan
- ADD: `req_decinst`=12'b000000110011, rs1=32'hc0404040, rs2=32'h00000fff → `alu_en` 1 cycle, `res_data`=32'hc040503f, `res_valid` 2 cycles after accept.
- SUB: decinst=12'b100000110011, same operands → `res_data`=32'hc0403041.
- SLTI: decinst=12'b000100010011, inm=32'h00000fff → `res_cmp`=1, since 0xc0404040 is negative.
- SRAI with an ALU model asserting `sl_ok` after 31 cycles: decinst=12'b011010010011, inm=32'h00000fff → `alu_en` held 32 cycles, `res_data`=32'hffffffff.
- Backpressure: `res_ready`=0 for 5 cycles → `res_valid` held, result stable, `req_ready`=0, a second request not accepted until after the handshake.
- Reset asserted mid-SHIFT → `alu_en`, `res_valid` drop to 0 immediately. With `ALU_ISSUE_TIMEOUT_EN` and `sl_ok` never asserted → `res_err`=1 after 40 cycles.
